// File: rtl/msg_pkg.sv
// Shared message-format definitions: widths, header field positions,
// the tap sequencer state enum and small helper functions.
package msg_pkg;

    localparam int MSG_WIDTH        = 32;
    localparam int MSG_LENGTH_WIDTH = 10;
    localparam int MSG_ID_WIDTH     = 10;

    // Header layout: flag | length | 4 zero bits | id | 7 zero bits
    localparam int HDR_FLAG_BIT = MSG_WIDTH - 1;
    localparam int HDR_LEN_LSB  = HDR_FLAG_BIT - MSG_LENGTH_WIDTH;
    localparam int HDR_ID_LSB   = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_TAPS = 2'd2
    } seq_state_t;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Builds a header word with all reserved bits zero.
    function automatic logic [MSG_WIDTH-1:0] pack_header(
        input logic [MSG_LENGTH_WIDTH-1:0] len,
        input logic [MSG_ID_WIDTH-1:0]     id
    );
        logic [MSG_WIDTH-1:0] w;
        w = '0;
        w[HDR_FLAG_BIT] = 1'b1;
        w[HDR_LEN_LSB +: MSG_LENGTH_WIDTH] = len;
        w[HDR_ID_LSB +: MSG_ID_WIDTH] = id;
        return w;
    endfunction

endpackage

// File: rtl/msg_header_decode.sv
// Combinational split of a message word into header fields and payload.
module msg_header_decode
    import msg_pkg::*;
(
    input  logic [MSG_WIDTH-1:0]        in_msg,
    output logic                        is_header,
    output logic [MSG_LENGTH_WIDTH-1:0] length,
    output logic [MSG_ID_WIDTH-1:0]     id,
    output logic [MSG_WIDTH-2:0]        payload
);

    // Field extraction; payload is everything below the header flag.
    always_comb begin
        is_header = in_msg[HDR_FLAG_BIT];
        length    = in_msg[HDR_LEN_LSB +: MSG_LENGTH_WIDTH];
        id        = in_msg[HDR_ID_LSB +: MSG_ID_WIDTH];
        payload   = in_msg[MSG_WIDTH-2:0];
    end

endmodule

// File: rtl/filterbank_tap_sequencer.sv
// Splits one filterbank coefficient load (header + N*FLTLEN taps) into N
// per-filter loads (header + FLTLEN taps) on the shared filter message bus.
//
// Handshake: an input word is consumed on any rising edge where
// in_msg_valid and in_msg_ready are both high; in_msg_ready is registered
// and does not depend on in_msg_valid. out_msg_nd is a one-cycle strobe
// with no back-pressure; out_sel names the filter that should take it.
module filterbank_tap_sequencer #(
    parameter int N                = 8,
    parameter int FLTLEN           = 10,
    parameter int ID               = 0,
    parameter int MSG_WIDTH        = 32,
    parameter int MSG_LENGTH_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [MSG_WIDTH-1:0]           in_msg,
    input  logic                           in_msg_valid,
    output logic                           in_msg_ready,
    output logic [MSG_WIDTH-1:0]           out_msg,
    output logic                           out_msg_nd,
    output logic [msg_pkg::clog2(N)-1:0]   out_sel,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic                           err_length,
    output logic                           err_abort,
    output msg_pkg::seq_state_t            dbg_state
);

    import msg_pkg::*;

    localparam int SEL_W = clog2(N);
    localparam int POS_W = clog2(FLTLEN);

    localparam logic [MSG_LENGTH_WIDTH-1:0] LOAD_LEN    = MSG_LENGTH_WIDTH'(N * FLTLEN);
    localparam logic [MSG_LENGTH_WIDTH-1:0] FLT_HDR_LEN = MSG_LENGTH_WIDTH'(FLTLEN);
    localparam logic [MSG_ID_WIDTH-1:0]     OWN_ID      = MSG_ID_WIDTH'(ID);
    localparam logic [POS_W-1:0]            LAST_POS    = POS_W'(FLTLEN - 1);
    localparam logic [SEL_W-1:0]            LAST_FILT   = SEL_W'(N - 1);

    seq_state_t             state;
    logic [SEL_W-1:0]       filt;
    logic [POS_W-1:0]       pos;

    logic                        dec_is_header;
    logic [MSG_LENGTH_WIDTH-1:0] dec_length;
    logic [MSG_ID_WIDTH-1:0]     dec_id;
    logic [MSG_WIDTH-2:0]        dec_payload;

    logic accept;
    logic hdr_match;
    logic hdr_good;
    logic hdr_bad;

    msg_header_decode u_decode (
        .in_msg    (in_msg),
        .is_header (dec_is_header),
        .length    (dec_length),
        .id        (dec_id),
        .payload   (dec_payload)
    );

    // Classification of the word currently offered on the input.
    always_comb begin
        accept    = in_msg_valid & in_msg_ready;
        hdr_match = dec_is_header && (dec_id == OWN_ID);
        hdr_good  = hdr_match && (dec_length == LOAD_LEN);
        hdr_bad   = hdr_match && (dec_length != LOAD_LEN);
    end

    assign dbg_state = state;

    // Sequencer FSM; ready and busy are registered alongside each state move.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            filt         <= '0;
            pos          <= '0;
            in_msg_ready <= 1'b0;
            out_msg      <= '0;
            out_msg_nd   <= 1'b0;
            out_sel      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_length   <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            out_msg_nd <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_msg_ready <= 1'b1;
                    busy         <= 1'b0;
                    if (accept && hdr_bad) begin
                        err_length <= 1'b1;
                        error      <= 1'b1;
                    end
                    if (accept && hdr_good) begin
                        filt         <= '0;
                        state        <= S_HDR;
                        in_msg_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end

                S_HDR: begin
                    // The per-filter header carries the filter index in its ID field.
                    out_msg      <= pack_header(FLT_HDR_LEN, MSG_ID_WIDTH'(filt));
                    out_msg_nd   <= 1'b1;
                    out_sel      <= filt;
                    pos          <= '0;
                    state        <= S_TAPS;
                    in_msg_ready <= 1'b1;
                    busy         <= 1'b1;
                end

                S_TAPS: begin
                    if (accept && dec_is_header) begin
                        // Any header aborts; it is then judged like an idle header.
                        err_abort <= 1'b1;
                        error     <= 1'b1;
                        if (hdr_bad) begin
                            err_length <= 1'b1;
                        end
                        if (hdr_good) begin
                            filt         <= '0;
                            state        <= S_HDR;
                            in_msg_ready <= 1'b0;
                            busy         <= 1'b1;
                        end else begin
                            state        <= S_IDLE;
                            in_msg_ready <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end else if (accept) begin
                        out_msg    <= {1'b0, dec_payload};
                        out_msg_nd <= 1'b1;
                        out_sel    <= filt;
                        if (pos == LAST_POS) begin
                            if (filt == LAST_FILT) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                filt         <= filt + SEL_W'(1);
                                state        <= S_HDR;
                                in_msg_ready <= 1'b0;
                            end
                        end else begin
                            pos <= pos + POS_W'(1);
                        end
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    in_msg_ready <= 1'b1;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filterbank_tap_sequencer.sv
// Bench for filterbank_tap_sequencer with N=4, FLTLEN=3, ID=2.
module tb_filterbank_tap_sequencer;
    import msg_pkg::*;

    localparam int N      = 4;
    localparam int FLTLEN = 3;
    localparam int FB_ID  = 2;
    localparam int SW     = 2;
    localparam int EW     = 32 + SW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]   in_msg = '0;
    logic          in_msg_valid = 1'b0;
    logic          in_msg_ready;
    logic [31:0]   out_msg;
    logic          out_msg_nd;
    logic [SW-1:0] out_sel;
    logic          busy, done, error, err_length, err_abort;
    seq_state_t    dbg_state;

    filterbank_tap_sequencer #(
        .N(N), .FLTLEN(FLTLEN), .ID(FB_ID), .MSG_WIDTH(32), .MSG_LENGTH_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst),
        .in_msg(in_msg), .in_msg_valid(in_msg_valid), .in_msg_ready(in_msg_ready),
        .out_msg(out_msg), .out_msg_nd(out_msg_nd), .out_sel(out_sel),
        .busy(busy), .done(done), .error(error),
        .err_length(err_length), .err_abort(err_abort), .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input int len, input int id);
        return 32'h8000_0000 | (32'(len) << 21) | (32'(id) << 7);
    endfunction

    function automatic logic [31:0] rnd_tap();
        return $urandom & 32'h7fff_ffff;
    endfunction

    // ---------------- reference model ----------------
    // Works on the stream of consumed words: a load is "active" from a good
    // header until N*FLTLEN taps have followed it; every FLTLEN taps open the
    // next filter's header. Expected strobes are {word, filter index}.
    logic [EW-1:0] exp_q[$];
    bit m_active = 0;
    int m_k = 0;
    bit m_err_len = 0;
    bit m_err_abort = 0;
    int exp_done = 0;
    int got_done = 0;
    int strobe_cnt = 0;
    int last_done_cyc = 0;
    int acc_cyc = 0;

    task automatic model_accept(input logic [31:0] w);
        int len;
        int id;
        if (w[31]) begin
            len = int'(w[30:21]);
            id  = int'(w[16:7]);
            if (m_active) m_err_abort = 1;
            m_active = 0;
            if (id == FB_ID) begin
                if (len == N * FLTLEN) begin
                    m_active = 1;
                    m_k = 0;
                    exp_q.push_back({mk_hdr(FLTLEN, 0), SW'(0)});
                end else begin
                    m_err_len = 1;
                end
            end
        end else if (m_active) begin
            exp_q.push_back({w, SW'(m_k / FLTLEN)});
            m_k++;
            if (m_k == N * FLTLEN) begin
                m_active = 0;
                exp_done++;
            end else if (m_k % FLTLEN == 0) begin
                exp_q.push_back({mk_hdr(FLTLEN, m_k / FLTLEN), SW'(m_k / FLTLEN)});
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 0;
        m_k = 0;
        m_err_len = 0;
        m_err_abort = 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (done) begin
                got_done++;
                last_done_cyc = cyc;
            end
            if (out_msg_nd) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %0h sel %0d, required no strobe (t=%0t)",
                             out_msg, out_sel, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_word_sel", {30'd0, out_msg, out_sel}, {30'd0, e});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns just after the rising edge that consumed w; valid stays high
    // until the next call or an explicit idle.
    task automatic send_word(input logic [31:0] w, input int gap);
        int tries;
        logic rdy;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_msg_valid = 1'b0;
            in_msg = $urandom;
        end
        tries = 0;
        @(negedge clk);
        in_msg = w;
        in_msg_valid = 1'b1;
        forever begin
            rdy = in_msg_ready;
            @(posedge clk);
            if (rdy) begin
                acc_cyc = cyc;
                model_accept(w);
                break;
            end
            tries++;
            if (tries > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: word %0h not consumed in 50 cycles", w);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        rst = 1'b1;
        in_msg_valid = 1'b0;
        model_reset();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_load(input int max_gap);
        send_word(mk_hdr(N * FLTLEN, FB_ID), $urandom_range(0, max_gap));
        for (int t = 0; t < N * FLTLEN; t++) send_word(rnd_tap(), $urandom_range(0, max_gap));
    endtask

    // Lets outstanding strobes and done drain, then compares against the model.
    task automatic drain_and_check(input string tag);
        @(negedge clk);
        in_msg_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done_count"}, 64'(got_done), 64'(exp_done));
        check({tag, "_err_length"}, 64'(err_length), 64'(m_err_len));
        check({tag, "_err_abort"}, 64'(err_abort), 64'(m_err_abort));
        check({tag, "_error"}, 64'(error), 64'(m_err_len | m_err_abort));
        check({tag, "_busy"}, 64'(busy), 64'(m_active));
    endtask

    // ---------------- IDLE-state vector table ----------------
    typedef struct {
        logic [31:0] word;
        logic        exp_busy;
        logic        exp_error;
        logic        exp_err_len;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int d0;

        vecs[0] = '{32'd5,                  1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd6,                  1'b0, 1'b0, 1'b0};
        vecs[2] = '{mk_hdr(12, 3),          1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'd7,                  1'b0, 1'b0, 1'b0};
        vecs[4] = '{mk_hdr(11, FB_ID),      1'b0, 1'b1, 1'b1};
        vecs[5] = '{mk_hdr(12, 0),          1'b0, 1'b1, 1'b1};
        vecs[6] = '{32'h7fff_ffff,          1'b0, 1'b1, 1'b1};

        // Reset values, during and after reset.
        repeat (2) @(negedge clk);
        check("rst_ready_low", 64'(in_msg_ready), 64'd0);
        check("rst_out_msg", 64'(out_msg), 64'd0);
        check("rst_nd", 64'(out_msg_nd), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(in_msg_ready), 64'd1);
        check("post_rst_out_msg", 64'(out_msg), 64'd0);
        check("post_rst_sel", 64'(out_sel), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_error", 64'(error), 64'd0);

        // Nominal load with exact timing of the first header and of done.
        s0 = strobe_cnt;
        d0 = got_done;
        send_word(mk_hdr(N * FLTLEN, FB_ID), 0);
        @(negedge clk);
        check("nom_hdr_busy", 64'(busy), 64'd1);
        check("nom_hdr_ready", 64'(in_msg_ready), 64'd0);
        check("nom_hdr_nd_quiet", 64'(out_msg_nd), 64'd0);
        in_msg = 32'd1;
        @(negedge clk);
        check("nom_h0_nd", 64'(out_msg_nd), 64'd1);
        check("nom_h0_word", 64'(out_msg), 64'(mk_hdr(FLTLEN, 0)));
        check("nom_h0_sel", 64'(out_sel), 64'd0);
        @(posedge clk);
        model_accept(32'd1);
        for (int t = 2; t <= N * FLTLEN; t++) send_word(32'(t), 0);
        drain_and_check("nominal");
        check("nom_strobes", 64'(strobe_cnt - s0), 64'(N * (FLTLEN + 1)));
        check("nom_done_once", 64'(got_done - d0), 64'd1);
        // Cycles from header acceptance to done, both counted inclusively.
        check("nom_duration", 64'(last_done_cyc - acc_cyc_hdr_nominal()), 64'(N * (FLTLEN + 1) + 1));

        // Stray taps, foreign IDs and a bad length while idle.
        s0 = strobe_cnt;
        for (int i = 0; i < 7; i++) begin
            send_word(vecs[i].word, 0);
            @(negedge clk);
            in_msg_valid = 1'b0;
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            check($sformatf("vec%0d_error", i), 64'(error), 64'(vecs[i].exp_error));
            check($sformatf("vec%0d_err_length", i), 64'(err_length), 64'(vecs[i].exp_err_len));
            check($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(S_IDLE));
            check($sformatf("vec%0d_ready", i), 64'(in_msg_ready), 64'd1);
        end
        check("vec_no_strobes", 64'(strobe_cnt - s0), 64'd0);
        run_load(0);
        drain_and_check("after_bad_len");

        // Abort after tap 5 and restart.
        do_reset(1);
        send_word(mk_hdr(N * FLTLEN, FB_ID), 0);
        for (int t = 1; t <= 5; t++) send_word(32'(t), 0);
        d0 = got_done;
        run_load(0);
        drain_and_check("abort");
        check("abort_flag", 64'(err_abort), 64'd1);
        check("abort_done", 64'(got_done - d0), 64'd1);

        // Valid gaps inside a load.
        do_reset(2);
        s0 = strobe_cnt;
        run_load(3);
        drain_and_check("gaps");
        check("gaps_strobes", 64'(strobe_cnt - s0), 64'(N * (FLTLEN + 1)));

        // Reset for one cycle after tap 7.
        do_reset(1);
        d0 = got_done;
        send_word(mk_hdr(N * FLTLEN, FB_ID), 0);
        for (int t = 1; t <= 7; t++) send_word(32'(t), 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        in_msg_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_ready", 64'(in_msg_ready), 64'd0);
        check("mid_rst_out_msg", 64'(out_msg), 64'd0);
        check("mid_rst_nd", 64'(out_msg_nd), 64'd0);
        check("mid_rst_sel", 64'(out_sel), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_rst_no_done", 64'(got_done - d0), 64'd0);
        run_load(1);
        drain_and_check("post_mid_rst");

        // Random mix of loads, foreign headers and interrupting headers.
        do_reset(1);
        for (int it = 0; it < 30; it++) begin
            int hsel;
            hsel = $urandom_range(0, 5);
            case (hsel)
                0:       send_word(mk_hdr(N * FLTLEN, 3), $urandom_range(0, 2));
                1:       send_word(mk_hdr(N * FLTLEN - 1, FB_ID), $urandom_range(0, 2));
                default: send_word(mk_hdr(N * FLTLEN, FB_ID), $urandom_range(0, 2));
            endcase
            for (int t = 0; t < N * FLTLEN + 2; t++) begin
                if ($urandom_range(0, 29) == 0)
                    send_word(mk_hdr(N * FLTLEN, FB_ID), $urandom_range(0, 2));
                else
                    send_word(rnd_tap(), $urandom_range(0, 2));
            end
        end
        drain_and_check("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Acceptance cycle of the nominal header, captured once on first use.
    int nominal_hdr_cyc = -1;
    always @(posedge clk) begin
        if (nominal_hdr_cyc < 0 && !rst && in_msg_valid && in_msg_ready && in_msg[31])
            nominal_hdr_cyc = cyc;
    end

    function automatic int acc_cyc_hdr_nominal();
        return nominal_hdr_cyc;
    endfunction

endmodule

// File: doc/filterbank_tap_sequencer.md
# filterbank_tap_sequencer

Controller that loads tap coefficients into a bank of N polyphase filters from a single message stream. It accepts one load request (a header followed by N*FLTLEN tap words) and re-emits it as N per-filter messages, each a header followed by FLTLEN taps. Its output drives the shared in_msg/in_msg_nd bus of the filter instances, and out_sel selects which filter listens. It sits between the filterbank's message buffer and the filter array.

## Interface
- N, 8: number of filters; N >= 2
- FLTLEN, 10: taps per filter; FLTLEN >= 2
- ID, 0: filterbank ID; headers carrying any other ID are ignored
- MSG_WIDTH, 32: message word width
- MSG_LENGTH_WIDTH, 10: header length-field width
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_msg  input  MSG_WIDTH  upstream message word
- in_msg_valid  input  1  in_msg is valid
- in_msg_ready  output  1  word is consumed in any cycle with valid & ready
- out_msg  output  MSG_WIDTH  word for the filter array
- out_msg_nd  output  1  out_msg is valid, single-cycle strobe
- out_sel  output  clog2(N)  target filter index for out_msg
- busy  output  1  a load is in progress
- done  output  1  one-cycle pulse after the last tap of filter N-1 is emitted
- error  output  1  sticky; OR of err_length and err_abort

## Operation
- Header word format: in_msg[MSG_WIDTH-1]=1, length in [30:21], 4 zero bits, ID in [16:7], 7 zero bits. Any word with MSB=0 is a tap.
- State IDLE: in_msg_ready=1.
  - Tap word: consumed and dropped.
  - Header with ID != ID: consumed and dropped. No error.
  - Header with matching ID and length != N*FLTLEN: consumed. Set err_length. Stay in IDLE.
  - Header with matching ID and length == N*FLTLEN: consumed. Set filt=0 and go to HDR.
- State HDR: in_msg_ready=0.
  - Emit out_msg = {1, FLTLEN, 4'b0, filt, 7'b0} with out_msg_nd=1 and out_sel=filt.
  - Clear pos to 0 and go to TAPS.
- State TAPS: in_msg_ready=1.
  - Tap word: emit it unchanged with out_sel=filt, then pos++.
  - If the accepted tap had pos==FLTLEN-1 and filt==N-1: go to IDLE and pulse done.
  - If the accepted tap had pos==FLTLEN-1 and filt<N-1: filt++ and go to HDR.
  - Header word: abort the load and set err_abort. The header is then evaluated exactly as in IDLE in the same cycle, so a valid header restarts the load at filt=0. Filters that were already loaded are not rolled back.
- busy=1 in HDR and TAPS.
- Counter widths: pos is clog2(FLTLEN) bits and filt is clog2(N) bits. Neither counter ever exceeds its terminal value.
- err_length and err_abort are cleared only by rst.

## Timing
- All outputs are registered.
- Reset values: in_msg_ready=0 during rst and 1 from the first cycle after; out_msg=0, out_msg_nd=0, out_sel=0, busy=0, done=0, error=0. State returns to IDLE.
- Header accepted on edge k: HDR output is valid in the cycle after edge k+1.
- Tap accepted on edge j: it is on out_msg in the cycle after edge j.
- One idle input cycle (ready=0) precedes each filter's taps.
- Minimum load duration is N*(FLTLEN+1)+1 cycles from header acceptance to done.
- in_msg_valid gaps stall TAPS with no output and no error. No timeout.
- rst asserted mid-load: the load is abandoned next edge, no done pulse, and out_msg_nd=0 from that edge on.
- out_msg_nd is never asserted in two different filters' headers without FLTLEN taps between them, except across an abort.

## Structure
- Shared package msg_pkg:
  - MSG_WIDTH, MSG_LENGTH_WIDTH
  - header field bit positions
  - clog2 function
  - header pack function
- One combinational sub-module, msg_header_decode: takes in_msg and produces is_header, length and id. It is reused by the filter and by this block.
- Sequencer FSM states IDLE, HDR, TAPS are an enum in msg_pkg.

## Test plan
Bench parameters are N=4, FLTLEN=3, ID=2 unless stated.
- **Nominal load.** Stimulus: header(len=12, id=2), then taps 1..12, continuously valid. Required response: 16 out strobes: H0,1,2,3, H1,4,5,6, H2,7,8,9, H3,10,11,12. out_sel is 0,0,0,0,1,1,1,1,… done pulses once, error=0, and the load takes 17 cycles header→done.
- **Foreign ID and stray taps.** Stimulus: taps 5,6, then header(id=3,len=12), then taps. Required response: all consumed, no out_msg_nd, busy=0, error=0.
- **Bad length.** Stimulus: header(id=2, len=11). Required response: err_length=1 and error=1, no output, state IDLE. A following correct load completes normally with error still 1.
- **Abort.** Stimulus: a valid load, then a new valid header after tap 5. Required response: err_abort=1; next output is H0 with out_sel=0, and 12 new taps complete with done.
- **Valid gaps.** Stimulus: random in_msg_valid deassertion during a load. Required response: output sequence identical to the nominal case, no error.
- **Reset mid-load.** Stimulus: rst for one cycle after tap 7. Required response: all outputs at reset values next cycle, no done; a subsequent load completes cleanly.
